rsa_modexp: RTL
===============

# rsa_modexp

Sequential modular-exponentiation engine that consumes the key material produced by the RSA key-generation stage: modulus N and an exponent, either public E or private D. It computes RES = MSG^EXP mod N with a right-to-left square-and-multiply loop, using one modular multiply per cycle. It sits directly downstream of `RSA_IP` in `top`: `OUT_N` drives `IN_N`, and `OUT_D` (or the public exponent) drives `IN_EXP`. One instance encrypts; a second instance with D decrypts.

## Interface
- `WIDTH`, default 4: prime width; all operands and the result are 2*WIDTH bits (KW = 2*WIDTH).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `IN_N`  in  KW  modulus; captured at accepted start.
- `IN_EXP`  in  KW  exponent; captured at accepted start.
- `IN_MSG`  in  KW  message/ciphertext; captured at accepted start. Values ≥ N are allowed.
- `busy`  out  1  high from the cycle after accept through the DONE cycle inclusive.
- `done`  out  1  one-cycle pulse; `OUT_RES` and `err` are valid from this cycle.
- `OUT_RES`  out  KW  registered result; held until the next `done`.
- `err`  out  1  set with `done` when the captured N == 0; held until the next `done`.

## Operation
- Registers:
  - `n_r`, `e_r`, `base_r`, `res_r`: KW bits each.
  - `idx`: bit index, width ⌈log2 KW⌉.
  - state: IDLE, MUL, SQR, DONE.
- Modular multiply: a*b is formed as a full 2*KW-bit product, then reduced mod `n_r`, truncated to KW bits. No intermediate overflow is permitted.
- IDLE with `start`=1 accepts the request. The next state depends on `IN_N`:
  - `IN_N` == 0: go to DONE with err_next=1 and res_next=0. No iteration.
  - `IN_N` ≠ 0: go to MUL with:
    - `n_r`=`IN_N`, `e_r`=`IN_EXP`
    - `base_r`=`IN_MSG` mod `IN_N`
    - `res_r`=1 mod `IN_N` (0 when N=1)
    - `idx`=0
- MUL: if `e_r[idx]`=1, `res_r` ← `res_r`*`base_r` mod N; otherwise `res_r` holds. Always go to SQR.
- SQR: `base_r` ← `base_r`² mod N.
  - If `idx` == KW-1, go to DONE.
  - Otherwise `idx`++ and go to MUL.
- DONE: `OUT_RES` ← `res_r` and `err` ← err_next, both registered. `done`=1 for exactly this cycle, then return to IDLE.
- The loop runs all KW exponent bits regardless of leading zeros, so latency is constant and data-independent.
- `start` while not in IDLE is ignored; there is no queuing. Inputs may change freely after accept.
- Input changes while in IDLE have no effect on outputs.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `OUT_RES`=0, `err`=0; all internal registers 0.
- Accept edge = T0. The iteration is MUL/SQR pairs occupying 2*KW cycles. DONE is the cycle T0+2*KW+1, where `done`=1.
- For `WIDTH`=4: `done` is high 17 cycles after the accept edge.
- Error path: `done`=1 one cycle after accept.
- The earliest next accept is the cycle after DONE, when `start` is sampled in IDLE. Back-to-back throughput is therefore one result per 2*KW+2 cycles.
- `start` held high continuously restarts the engine on every IDLE cycle using the current inputs.
- `rst_n` asserted mid-operation aborts immediately. Everything returns to reset values and `done` is not pulsed.
- `done` and `busy` are registered, glitch-free outputs.

## Test plan
- Reset mid-run: assert `rst_n`=0 at cycle 8 of a run → `busy`, `done`, `OUT_RES` and `err` are all 0 immediately, and no `done` pulse occurs. A new start after reset gives a correct result.
- Encrypt/decrypt pair, N=33 (p=3, q=11), E=3, D=7:
  - MSG=4 → `OUT_RES`=31, `err`=0, `done` exactly 17 cycles after accept.
  - Then start with MSG=31, EXP=7 → `OUT_RES`=4.
- Larger key, N=143 (11*13), EXP=7, MSG=2 → 128. Then EXP=103, MSG=128 → 2.
- Boundary operands:
  - N=33, EXP=0, MSG=5 → 1.
  - N=1, any EXP/MSG → 0.
  - N=33, EXP=1, MSG=40 → 7 (input reduction).
  - N=255, EXP=255, MSG=254 → 254 (no product overflow).
- Error and handshake:
  - N=0 → `done` one cycle after accept, `err`=1, `OUT_RES`=0.
  - `start` pulsed while `busy` → ignored; the original result is unchanged.
  - `start` held high → consecutive results 18 cycles apart.
- Integration: drive from `top` with the counter → for each cycle where `OUT_N`≠0, an encrypt/decrypt round trip with E/D returns the original MSG.

Source files
------------

// File: rtl/rsa_modexp.sv
// Sequential modular exponentiation RES = MSG^EXP mod N, right-to-left square-and-multiply.
// One shared modular multiplier is used each cycle: it reduces the message at accept and runs MUL/SQR steps.
module rsa_modexp #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*WIDTH-1:0] IN_N,
    input  logic [2*WIDTH-1:0] IN_EXP,
    input  logic [2*WIDTH-1:0] IN_MSG,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] OUT_RES,
    output logic               err
);

    localparam int KW = 2 * WIDTH;
    localparam int PW = 2 * KW;
    localparam int IW = (KW > 1) ? $clog2(KW) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(KW - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_SQR,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [KW-1:0]   r_n;
    logic [KW-1:0]   r_e;
    logic [KW-1:0]   r_base;
    logic [KW-1:0]   r_res;
    logic [IW-1:0]   r_idx;
    logic            r_err_next;

    logic [KW-1:0]   w_mul_a;
    logic [KW-1:0]   w_mul_b;
    logic [KW-1:0]   w_mod_n;
    logic [PW-1:0]   w_prod;
    logic [KW-1:0]   w_mod_out;
    logic            w_accept;
    logic            w_last_bit;

    // Restoring shift-subtract reduction of the full product; the remainder stays below 2*n.
    // NOTE: blocking assignments are correct here: rem is a scratch variable evaluated in loop order.
    function automatic logic [KW-1:0] mod_reduce(input logic [PW-1:0] p, input logic [KW-1:0] n);
        logic [KW:0] rem;
        rem = '0;
        for (int i = PW - 1; i >= 0; i--) begin
            rem = {rem[KW-1:0], p[i]};
            if (rem >= {1'b0, n}) begin
                rem = rem - {1'b0, n};
            end
        end
        return rem[KW-1:0];
    endfunction

    assign w_accept   = (r_state == S_IDLE) && start;
    assign w_last_bit = (r_idx == IDX_LAST);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_mul_a = r_res;
        w_mul_b = r_base;
        w_mod_n = r_n;
        unique case (r_state)
            S_IDLE: begin
                w_mul_a = IN_MSG;
                w_mul_b = KW'(1);
                w_mod_n = IN_N;
            end
            S_SQR: begin
                w_mul_a = r_base;
                w_mul_b = r_base;
            end
            default: ;
        endcase
    end

    assign w_prod    = {{KW{1'b0}}, w_mul_a} * {{KW{1'b0}}, w_mul_b};
    assign w_mod_out = mod_reduce(w_prod, w_mod_n);

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (IN_N == '0) ? S_DONE : S_MUL;
                end
            end
            S_MUL:  w_next_state = S_SQR;
            S_SQR:  w_next_state = w_last_bit ? S_DONE : S_MUL;
            S_DONE: w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_n        <= '0;
            r_e        <= '0;
            r_base     <= '0;
            r_res      <= '0;
            r_idx      <= '0;
            r_err_next <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_n   <= IN_N;
                        r_e   <= IN_EXP;
                        r_idx <= '0;
                        if (IN_N == '0) begin
                            r_err_next <= 1'b1;
                            r_res      <= '0;
                            r_base     <= '0;
                        end else begin
                            r_err_next <= 1'b0;
                            r_base     <= w_mod_out;
                            r_res      <= (IN_N == KW'(1)) ? '0 : KW'(1);
                        end
                    end
                end
                S_MUL: begin
                    if (r_e[r_idx]) begin
                        r_res <= w_mod_out;
                    end
                end
                S_SQR: begin
                    r_base <= w_mod_out;
                    if (!w_last_bit) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are registered; done/OUT_RES/err update on the edge that leaves DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            OUT_RES <= '0;
            err     <= 1'b0;
        end else begin
            busy <= (w_next_state != S_IDLE) || (r_state == S_DONE);
            done <= (r_state == S_DONE);
            if (r_state == S_DONE) begin
                OUT_RES <= r_res;
                err     <= r_err_next;
            end
        end
    end

endmodule
